// File: rtl/mnist_pixel_streamer_if.sv
// Bus bundle for mnist_pixel_streamer: frame-memory write port, stream control
// inputs and the raster pixel stream with its frame markers.
interface mnist_pixel_streamer_if #(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 28,
  parameter int DATA_BITS = 8
);
  localparam int ADDR_BITS = $clog2(WIDTH * HEIGHT);

  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0] wr_data;
  logic                 start;
  logic                 stop;
  logic                 hold;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 sof;
  logic                 eol;
  logic                 eof;
  logic                 busy;
  logic                 done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, hold,
    input  data_out, valid_out, sof, eol, eof, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, hold,
    output data_out, valid_out, sof, eol, eof, busy, done
  );
endinterface

// File: rtl/mnist_pixel_streamer.sv
// Frame source: holds one WIDTH x HEIGHT image and streams it in raster order with sof/eol/eof.
// Define MNIST_STREAMER_LOOP_EN to repeat frames back-to-back until a stop request.
module mnist_pixel_streamer #(
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28,
  parameter int DATA_BITS  = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mnist_pixel_streamer_if.slave  bus
);
  localparam int DEPTH     = WIDTH * HEIGHT;
  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int COL_BITS  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_BITS  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int GAP_BITS  = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
  state_t state_q, state_d;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] pix_cnt;
  logic [COL_BITS-1:0]  col_cnt;
  logic [ROW_BITS-1:0]  row_cnt;
  logic [GAP_BITS-1:0]  gap_cnt;

  logic last_pix, last_col, last_row, last_gap;
  logic emit, restart, gap_exit, wr_ok, stop_now;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, sof_q, eol_q, eof_q, done_q;

  assign last_pix = (pix_cnt == ADDR_BITS'(DEPTH - 1));
  assign last_col = (col_cnt == COL_BITS'(WIDTH - 1));
  assign last_row = (row_cnt == ROW_BITS'(HEIGHT - 1));
  assign last_gap = (gap_cnt == GAP_BITS'(GAP_CYCLES - 1));

  // The extra address bit keeps the range check correct when DEPTH is a power of two.
  assign wr_ok = bus.wr_en && (state_q == IDLE) &&
                 ({1'b0, bus.wr_addr} < (ADDR_BITS + 1)'(DEPTH));

  // NOTE: the frame memory has no reset on purpose; the image must survive rst_n so a
  // restart after an aborted frame replays the retained contents.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
  end

`ifdef MNIST_STREAMER_LOOP_EN
  logic stop_req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stop_req_q <= 1'b0;
    else if (state_d == IDLE)                   stop_req_q <= 1'b0;
    else if (state_q != IDLE && bus.stop)       stop_req_q <= 1'b1;
  end

  assign stop_now = stop_req_q || bus.stop;
`else
  logic unused_stop;
  assign unused_stop = bus.stop;
  assign stop_now    = 1'b1;
`endif

  // NOTE: every signal driven here gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    restart  = 1'b0;
    gap_exit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          restart = 1'b1;
        end
      end
      STREAM: begin
        if (!bus.hold) begin
          emit = 1'b1;
          if (last_pix) state_d = GAP;
        end
      end
      GAP: begin
        if (last_gap) begin
          gap_exit = 1'b1;
          if (stop_now) begin
            state_d = IDLE;
          end else begin
            state_d = STREAM;
            restart = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      gap_cnt <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= emit;
      sof_q   <= emit && (pix_cnt == '0);
      eol_q   <= emit && last_col;
      eof_q   <= emit && last_pix;
      done_q  <= gap_exit;
      if (emit) data_q <= mem[pix_cnt];

      if (restart) begin
        pix_cnt <= '0;
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (emit) begin
        pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        col_cnt <= last_col ? '0 : col_cnt + 1'b1;
        if (last_col) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end

      if (emit && last_pix)      gap_cnt <= '0;
      else if (state_q == GAP)   gap_cnt <= last_gap ? '0 : gap_cnt + 1'b1;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.sof       = sof_q;
  assign bus.eol       = eol_q;
  assign bus.eof       = eof_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
